// File: rtl/digest_uart_tx.sv
// digest_uart_tx
//   Transmit end of the hash-result serial link. The block latches a digest
//   when tx_start is seen in IDLE. It then sends the digest as DIGEST_BYTES
//   back-to-back 8N1 UART frames, most-significant byte first and LSB first
//   within each byte. When the last stop bit ends, it raises spart_done for
//   one cycle.
//
// Ports
//   clk         in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   tx_start    in   send request; only looked at while idle
//   digest      in   8*DIGEST_BYTES-bit value, captured on the accepting edge
//   txd         out  serial line, idles high (registered)
//   busy        out  high from the accepting edge until the DONE cycle
//   spart_done  out  one-cycle pulse once every byte has been sent
//   byte_idx    out  index of the byte currently on the line (0 = MSB)
module digest_uart_tx #(
  parameter int CLK_DIV      = 434,
  parameter int DIGEST_BYTES = 20
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      tx_start,
  input  logic [8*DIGEST_BYTES-1:0] digest,
  output logic                      txd,
  output logic                      busy,
  output logic                      spart_done,
  output logic [4:0]                byte_idx
);

  localparam int            DW        = 8 * DIGEST_BYTES;
  localparam int            BW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);
  localparam logic [4:0]    LAST_BYTE = 5'(DIGEST_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_DONE
  } state_t;

  state_t        state_reg, state_next;
  logic [BW-1:0] baud_reg,  baud_next;
  logic [2:0]    bit_reg,   bit_next;
  logic [4:0]    idx_reg,   idx_next;
  logic [DW-1:0] shift_reg, shift_next;
  logic          txd_reg,   txd_next;
  logic          busy_reg,  busy_next;
  logic          done_reg,  done_next;

  logic          bit_end;
  logic [7:0]    cur_byte;

  // The last cycle of every bit period, whatever the state.
  assign bit_end  = (baud_reg == BAUD_LAST);
  // The byte being sent always sits in the top of the shift register.
  assign cur_byte = shift_reg[DW-1 -: 8];

  always_comb begin
    state_next = state_reg;
    baud_next  = bit_end ? '0 : baud_reg + BW'(1);
    bit_next   = bit_reg;
    idx_next   = idx_reg;
    shift_next = shift_reg;
    txd_next   = txd_reg;
    busy_next  = busy_reg;
    done_next  = 1'b0;

    case (state_reg)
      S_IDLE: begin
        baud_next = '0;
        txd_next  = 1'b1;
        busy_next = 1'b0;
        if (tx_start) begin
          // The start bit goes out on the accepting edge itself.
          state_next = S_START;
          shift_next = digest;
          idx_next   = '0;
          bit_next   = '0;
          busy_next  = 1'b1;
          txd_next   = 1'b0;
        end
      end

      S_START: begin
        if (bit_end) begin
          state_next = S_DATA;
          bit_next   = '0;
          txd_next   = cur_byte[0];
        end
      end

      S_DATA: begin
        if (bit_end) begin
          if (bit_reg == 3'd7) begin
            state_next = S_STOP;
            txd_next   = 1'b1;
          end else begin
            bit_next = bit_reg + 3'd1;
            txd_next = cur_byte[bit_next];
          end
        end
      end

      S_STOP: begin
        if (bit_end) begin
          if (idx_reg < LAST_BYTE) begin
            // Next start bit follows the stop bit directly, no idle gap.
            state_next = S_START;
            idx_next   = idx_reg + 5'd1;
            shift_next = {shift_reg[DW-9:0], 8'h00};
            txd_next   = 1'b0;
          end else begin
            state_next = S_DONE;
            baud_next  = '0;
            txd_next   = 1'b1;
            busy_next  = 1'b0;
            done_next  = 1'b1;
          end
        end
      end

      S_DONE: begin
        // tx_start is deliberately not looked at here; a held request is
        // only taken again from the following IDLE cycle.
        state_next = S_IDLE;
        baud_next  = '0;
        txd_next   = 1'b1;
        busy_next  = 1'b0;
      end

      default: begin
        state_next = S_IDLE;
        baud_next  = '0;
        txd_next   = 1'b1;
        busy_next  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
      baud_reg  <= '0;
      bit_reg   <= '0;
      idx_reg   <= '0;
      shift_reg <= '0;
      txd_reg   <= 1'b1;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      baud_reg  <= baud_next;
      bit_reg   <= bit_next;
      idx_reg   <= idx_next;
      shift_reg <= shift_next;
      txd_reg   <= txd_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
    end
  end

  assign txd        = txd_reg;
  assign busy       = busy_reg;
  assign spart_done = done_reg;
  assign byte_idx   = idx_reg;

endmodule
